// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm generator / capture pair: duty encoding,
// default period and the capture FSM state encoding.
package pwm_pkg;
  localparam int DUTY_W = 7;
  localparam int DUTY_MAX = 100;
  localparam int PERIOD_TICKS_DEFAULT = 100;

  typedef enum logic {
    SEARCH  = 1'b0,
    MEASURE = 1'b1
  } cap_state_t;
endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes pwm_in, optionally glitch-filters it on the sample tick, and
// flags rise/fall on the tick-qualified level. Filter: PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_edge_sync #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic pwm_in,
  output logic cur,
  output logic rise,
  output logic fall,
  output logic smp
);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif
  localparam int FW = (FILTER_TICKS > 1) ? $clog2(FILTER_TICKS + 1) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [FW-1:0]          fcnt;
  logic                   prev;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      fcnt <= '0;
      prev <= 1'b0;
      cur  <= 1'b0;
      smp  <= 1'b0;
    end else begin
      sync[0] <= pwm_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      smp <= tick;
      // Without the filter every differing sample is accepted immediately.
      if (tick) begin
        prev <= cur;
        if (s == cur) begin
          fcnt <= '0;
        end else if (!FILTER_EN || fcnt == FW'(FILTER_TICKS - 1)) begin
          cur  <= s;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // smp marks the clk where the freshly ticked prev/cur pair is visible.
  assign rise = smp & ~prev & cur;
  assign fall = smp & prev & ~cur;
endmodule

// File: rtl/pwm_capture.sv
// Measures rise-to-rise PWM periods on the 1 MHz tick and reports duty 0..100,
// with period-tolerance and stuck-level detection. Filter: PWM_CAPTURE_GLITCH_FILTER_EN.
import pwm_pkg::*;

module pwm_capture #(
  parameter int PERIOD_TICKS = PERIOD_TICKS_DEFAULT,
  parameter int TOLERANCE    = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_TICKS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              one_MHz_enable,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              duty_valid,
  output logic              period_error
);
  localparam int CNT_W = $clog2(PERIOD_TICKS + TOLERANCE + 2);
  localparam logic [CNT_W-1:0] STUCK = CNT_W'(PERIOD_TICKS + TOLERANCE + 1);

  cap_state_t       state;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic             level;
  logic             rise;
  logic             fall;
  logic             smp;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [DUTY_W-1:0] clip_duty(input logic [CNT_W-1:0] v);
    if (int'(v) > DUTY_MAX) return DUTY_W'(DUTY_MAX);
    return DUTY_W'(v);
  endfunction

  function automatic logic in_tol(input logic [CNT_W-1:0] v);
    int p;
    p = int'(v);
    return (p >= PERIOD_TICKS - TOLERANCE) && (p <= PERIOD_TICKS + TOLERANCE);
  endfunction

  pwm_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_TICKS(FILTER_TICKS)
  ) u_edge (
    .clk   (clk),
    .reset (reset),
    .tick  (one_MHz_enable),
    .pwm_in(pwm_in),
    .cur   (level),
    .rise  (rise),
    .fall  (fall),
    .smp   (smp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SEARCH;
      per_cnt      <= '0;
      high_cnt     <= '0;
      idle_cnt     <= '0;
      duty_cycle   <= '0;
      duty_valid   <= 1'b0;
      period_error <= 1'b0;
    end else begin
      duty_valid   <= 1'b0;
      period_error <= 1'b0;
      if (smp) begin
        if (rise) begin
          // A rise both closes the running period and opens the next one.
          if (state == MEASURE) begin
            if (in_tol(per_cnt)) begin
              duty_cycle <= clip_duty(high_cnt);
              duty_valid <= 1'b1;
            end else begin
              period_error <= 1'b1;
            end
          end
          idle_cnt <= '0;
          per_cnt  <= CNT_W'(1);
          high_cnt <= CNT_W'(1);
          state    <= MEASURE;
        end else if (!fall && sat_inc(idle_cnt) == STUCK) begin
          duty_cycle <= level ? DUTY_W'(DUTY_MAX) : '0;
          duty_valid <= 1'b1;
          idle_cnt   <= '0;
          per_cnt    <= '0;
          high_cnt   <= '0;
          state      <= SEARCH;
        end else begin
          idle_cnt <= fall ? '0 : sat_inc(idle_cnt);
          if (state == MEASURE) begin
            per_cnt <= sat_inc(per_cnt);
            if (level) high_cnt <= sat_inc(high_cnt);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a table of PWM periods plus hand-written
// reset, stuck-level and glitch sequences.
module tb_pwm_capture;
  logic       clk = 1'b0;
  logic       reset;
  logic       one_MHz_enable;
  logic       pwm_in;
  logic [6:0] duty_cycle;
  logic       duty_valid;
  logic       period_error;

  always #5 clk = ~clk;

  pwm_capture dut (
    .clk           (clk),
    .reset         (reset),
    .one_MHz_enable(one_MHz_enable),
    .pwm_in        (pwm_in),
    .duty_cycle    (duty_cycle),
    .duty_valid    (duty_valid),
    .period_error  (period_error)
  );

  typedef struct {
    int is_err;
    int duty;
  } exp_t;

  typedef struct {
    int high;
    int per;
    int has_exp;
    int is_err;
    int duty;
  } vec_t;

  exp_t sb[$];
  int   evt_tick[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   tick_idx = 0;
  vec_t vecs[14];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int e, input int d);
    exp_t x;
    x.is_err = e;
    x.duty   = d;
    sb.push_back(x);
  endtask

  task automatic do_tick(input logic lv);
    pwm_in = lv;
    repeat (3) @(negedge clk);
    one_MHz_enable = 1'b1;
    @(negedge clk);
    one_MHz_enable = 1'b0;
    tick_idx++;
  endtask

  task automatic drive(input logic lv, input int n);
    repeat (n) do_tick(lv);
  endtask

  task automatic period(input int h, input int p);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (duty_valid || period_error) begin
      evt_tick.push_back(tick_idx);
      check("exclusive pulses", int'(duty_valid && period_error), 0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected pulse: valid=%0d error=%0d duty=%0d, required no pulse",
                 duty_valid, period_error, duty_cycle);
      end else begin
        x = sb.pop_front();
        check("pulse kind (1=period_error)", int'(period_error), x.is_err);
        check("duty_cycle at pulse", int'(duty_cycle), x.duty);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    vecs = '{'{30, 100, 0, 0, 0},  '{30, 100, 1, 0, 30}, '{37, 100, 1, 0, 30},
             '{37, 100, 1, 0, 37}, '{37, 100, 1, 0, 37}, '{50, 110, 1, 0, 37},
             '{50, 110, 1, 1, 37}, '{49, 98, 1, 1, 37},  '{49, 98, 1, 0, 49},
             '{60, 102, 1, 0, 49}, '{20, 103, 1, 0, 60}, '{45, 97, 1, 1, 60},
             '{5, 100, 1, 1, 60},  '{101, 102, 1, 0, 5}};

    reset = 1'b1;
    pwm_in = 1'b0;
    one_MHz_enable = 1'b0;
    repeat (4) @(negedge clk);
    check("reset duty_cycle", int'(duty_cycle), 0);
    check("reset duty_valid", int'(duty_valid), 0);
    check("reset period_error", int'(period_error), 0);
    reset = 1'b0;

    // Measure one period, then reset in the middle of the next one.
    period(30, 100);
    push(0, 30);
    drive(1'b1, 30);
    drive(1'b0, 20);
    check("duty before reset", int'(duty_cycle), 30);
    reset = 1'b1;
    #1;
    check("async reset clears duty", int'(duty_cycle), 0);
    drive(1'b0, 10);
    check("duty held in reset", int'(duty_cycle), 0);
    reset = 1'b0;
    drive(1'b0, 20);
    check("pending after reset section", sb.size(), 0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].has_exp != 0) push(vecs[i].is_err, vecs[i].duty);
      period(vecs[i].high, vecs[i].per);
    end

    // Stuck high: closing rise of the last table period, then two timeouts.
    n0 = evt_tick.size();
    push(0, 100);
    push(0, 100);
    push(0, 100);
    drive(1'b1, 300);
    check("events while stuck high", evt_tick.size() - n0, 3);
    if (evt_tick.size() >= n0 + 3) begin
      check("first stuck-high gap", evt_tick[n0+1] - evt_tick[n0], 103);
      check("second stuck-high gap", evt_tick[n0+2] - evt_tick[n0+1], 103);
    end

    n0 = evt_tick.size();
    push(0, 0);
    push(0, 0);
    drive(1'b0, 300);
    check("events while stuck low", evt_tick.size() - n0, 2);
    if (evt_tick.size() >= n0 + 2)
      check("stuck-low repeat gap", evt_tick[n0+1] - evt_tick[n0], 103);

    // 50% period with a one-tick low glitch in the middle of the high phase.
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    push(1, 0);
`endif
    drive(1'b1, 25);
    drive(1'b0, 1);
    drive(1'b1, 24);
    drive(1'b0, 50);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    push(0, 50);
`else
    push(1, 0);
`endif
    period(50, 100);
    push(0, 50);
    period(50, 100);

    repeat (40) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
